// File: rtl/fft_ctrl_pkg.sv
// Shared FSM encodings and helpers for the OFDM symbol sequencer in front of myFFT.
package fft_ctrl_pkg;

    typedef enum logic [2:0] {
        IN_IDLE,
        IN_SKIP_CP,
        IN_FEED,
        IN_FILL,
        IN_DROP
    } in_state_t;

    typedef enum logic {
        OUT_WAIT,
        OUT_DRAIN
    } out_state_t;

    function automatic int nfft(input int size_buffer);
        return 1 << size_buffer;
    endfunction

    // Status counters are at most 32 bits; the caller supplies its own all-ones limit.
    function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] vmax);
        return (v >= vmax) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/fft_out_tagger.sv
// Drains one myFFT result burst, registering each sample with its bin index and a last flag.
module fft_out_tagger
    import fft_ctrl_pkg::*;
#(
    parameter int SIZE_BUFFER   = 8,
    parameter int DATA_OUT_SIZE = 22
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     i_block,
    input  logic                     i_out_ready,
    input  logic                     i_complete,
    input  logic [DATA_OUT_SIZE-1:0] i_data_i,
    input  logic [DATA_OUT_SIZE-1:0] i_data_q,
    output logic                     o_ready,
    output logic                     o_valid,
    output logic [DATA_OUT_SIZE-1:0] o_i,
    output logic [DATA_OUT_SIZE-1:0] o_q,
    output logic [SIZE_BUFFER-1:0]   o_bin,
    output logic                     o_last,
    output logic                     o_err
);

    localparam logic [SIZE_BUFFER-1:0] LAST = SIZE_BUFFER'(nfft(SIZE_BUFFER) - 1);

    out_state_t                 r_state, w_state_nxt;
    logic [SIZE_BUFFER-1:0]     r_bin;
    logic                       r_err_seen;
    logic                       r_valid, r_last;
    logic [DATA_OUT_SIZE-1:0]   r_i, r_q;
    logic [SIZE_BUFFER-1:0]     r_bin_out;
    logic                       w_ready, w_take, w_err;

    // myFFT cannot stall, so once a burst starts we accept every sample of it.
    assign w_ready = (r_state == OUT_DRAIN) | (i_out_ready & ~i_block);
    assign w_take  = i_complete & w_ready;

    always_comb begin
        w_state_nxt = r_state;
        w_err       = 1'b0;
        case (r_state)
            OUT_WAIT:  if (w_take) w_state_nxt = OUT_DRAIN;
            OUT_DRAIN: begin
                w_err = ~i_out_ready & ~r_err_seen;
                if (w_take && r_bin == LAST) w_state_nxt = OUT_WAIT;
            end
            default:   w_state_nxt = OUT_WAIT;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= OUT_WAIT;
            r_bin      <= '0;
            r_err_seen <= 1'b0;
            r_valid    <= 1'b0;
            r_last     <= 1'b0;
            r_i        <= '0;
            r_q        <= '0;
            r_bin_out  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_valid <= w_take;
            r_last  <= w_take & (r_bin == LAST);
            if (r_state == OUT_WAIT) r_err_seen <= 1'b0;
            else if (w_err)          r_err_seen <= 1'b1;
            if (w_take) begin
                r_i       <= i_data_i;
                r_q       <= i_data_q;
                r_bin_out <= r_bin;
                r_bin     <= r_bin + 1'b1;
            end
        end
    end

    assign o_ready = w_ready;
    assign o_valid = r_valid;
    assign o_i     = r_i;
    assign o_q     = r_q;
    assign o_bin   = r_bin_out;
    assign o_last  = r_last;
    assign o_err   = w_err;

endmodule

// File: rtl/fft_frame_ctrl.sv
// OFDM symbol sequencer: strips the cyclic prefix, feeds NFFT samples to myFFT, tags its results.
module fft_frame_ctrl
    import fft_ctrl_pkg::*;
#(
    parameter int SIZE_BUFFER   = 8,
    parameter int DATA_FFT_SIZE = 16,
    parameter int DATA_OUT_SIZE = 22,
    parameter int CNT_W         = 16
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     enable,
    input  logic [SIZE_BUFFER-1:0]   cp_len,
    input  logic                     sym_start,
    input  logic                     in_valid,
    input  logic [DATA_FFT_SIZE-1:0] in_i,
    input  logic [DATA_FFT_SIZE-1:0] in_q,
    output logic                     fft_reset,
    output logic                     fft_valid,
    output logic [DATA_FFT_SIZE-1:0] fft_data_i,
    output logic [DATA_FFT_SIZE-1:0] fft_data_q,
    input  logic                     fft_wayt_data,
    output logic                     fft_ready_recive,
    input  logic                     fft_complete,
    input  logic [DATA_OUT_SIZE-1:0] fft_out_i,
    input  logic [DATA_OUT_SIZE-1:0] fft_out_q,
    input  logic                     out_ready,
    output logic                     out_valid,
    output logic [DATA_OUT_SIZE-1:0] out_i,
    output logic [DATA_OUT_SIZE-1:0] out_q,
    output logic [SIZE_BUFFER-1:0]   out_bin,
    output logic                     out_last,
    output logic                     busy,
    output logic [CNT_W-1:0]         sym_cnt,
    output logic [CNT_W-1:0]         overrun_cnt,
    output logic [CNT_W-1:0]         sync_err_cnt,
    output logic [CNT_W-1:0]         out_err_cnt
);

    localparam logic [SIZE_BUFFER-1:0] LAST    = SIZE_BUFFER'(nfft(SIZE_BUFFER) - 1);
    localparam logic [31:0]            CNT_MAX = 32'((64'd1 << CNT_W) - 64'd1);

    in_state_t                  r_state, w_state_nxt;
    logic [SIZE_BUFFER-1:0]     r_cnt, w_cnt_nxt;
    logic [SIZE_BUFFER-1:0]     r_cp, w_cp_nxt;
    logic [1:0]                 r_rst_sr;
    logic                       r_fft_valid;
    logic [DATA_FFT_SIZE-1:0]   r_fft_i, r_fft_q;
    logic [CNT_W-1:0]           r_sym_cnt, r_ovr_cnt, r_sync_cnt, r_oerr_cnt;
    logic                       w_sym, w_feed, w_pad;
    logic                       w_inc_sym, w_inc_ovr, w_inc_sync, w_out_err;

    assign w_sym = sym_start & in_valid;

    // r_cnt counts discarded CP samples in SKIP_CP and FFT samples delivered in FEED/FILL.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_cp_nxt    = r_cp;
        w_feed      = 1'b0;
        w_pad       = 1'b0;
        w_inc_sym   = 1'b0;
        w_inc_ovr   = 1'b0;
        w_inc_sync  = 1'b0;
        case (r_state)
            IN_IDLE, IN_DROP: begin
                if (w_sym) begin
                    if (!enable) begin
                        w_state_nxt = IN_IDLE;
                    end else if (!fft_wayt_data) begin
                        w_state_nxt = IN_DROP;
                        w_inc_ovr   = 1'b1;
                    end else if (cp_len == '0) begin
                        w_state_nxt = IN_FEED;
                        w_feed      = 1'b1;
                        w_cnt_nxt   = SIZE_BUFFER'(1);
                    end else begin
                        w_state_nxt = IN_SKIP_CP;
                        w_cp_nxt    = cp_len;
                        w_cnt_nxt   = SIZE_BUFFER'(1);
                    end
                end
            end
            IN_SKIP_CP: begin
                if (w_sym) begin
                    w_state_nxt = IN_FILL;
                    w_inc_sync  = 1'b1;
                    w_cnt_nxt   = '0;
                end else if (in_valid) begin
                    if (r_cnt == r_cp) begin
                        w_state_nxt = IN_FEED;
                        w_feed      = 1'b1;
                        w_cnt_nxt   = SIZE_BUFFER'(1);
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
            end
            IN_FEED: begin
                if (w_sym) begin
                    w_state_nxt = IN_FILL;
                    w_inc_sync  = 1'b1;
                end else if (in_valid) begin
                    w_feed    = 1'b1;
                    w_cnt_nxt = r_cnt + 1'b1;
                    if (r_cnt == LAST) begin
                        w_state_nxt = IN_IDLE;
                        w_inc_sym   = 1'b1;
                    end
                end
            end
            IN_FILL: begin
                w_pad     = 1'b1;
                w_cnt_nxt = r_cnt + 1'b1;
                w_inc_ovr = w_sym;
                if (r_cnt == LAST) w_state_nxt = IN_IDLE;
            end
            default: w_state_nxt = IN_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= IN_IDLE;
            r_cnt       <= '0;
            r_cp        <= '0;
            r_rst_sr    <= 2'b11;
            r_fft_valid <= 1'b0;
            r_fft_i     <= '0;
            r_fft_q     <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_cp        <= w_cp_nxt;
            r_rst_sr    <= {r_rst_sr[0], 1'b0};
            r_fft_valid <= w_feed | w_pad;
            r_fft_i     <= w_feed ? in_i : '0;
            r_fft_q     <= w_feed ? in_q : '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sym_cnt  <= '0;
            r_ovr_cnt  <= '0;
            r_sync_cnt <= '0;
            r_oerr_cnt <= '0;
        end else begin
            if (w_inc_sym)  r_sym_cnt  <= CNT_W'(sat_inc(32'(r_sym_cnt),  CNT_MAX));
            if (w_inc_ovr)  r_ovr_cnt  <= CNT_W'(sat_inc(32'(r_ovr_cnt),  CNT_MAX));
            if (w_inc_sync) r_sync_cnt <= CNT_W'(sat_inc(32'(r_sync_cnt), CNT_MAX));
            if (w_out_err)  r_oerr_cnt <= CNT_W'(sat_inc(32'(r_oerr_cnt), CNT_MAX));
        end
    end

    fft_out_tagger #(
        .SIZE_BUFFER   (SIZE_BUFFER),
        .DATA_OUT_SIZE (DATA_OUT_SIZE)
    ) u_tagger (
        .clk         (clk),
        .reset_n     (reset_n),
        .i_block     (fft_reset),
        .i_out_ready (out_ready),
        .i_complete  (fft_complete),
        .i_data_i    (fft_out_i),
        .i_data_q    (fft_out_q),
        .o_ready     (fft_ready_recive),
        .o_valid     (out_valid),
        .o_i         (out_i),
        .o_q         (out_q),
        .o_bin       (out_bin),
        .o_last      (out_last),
        .o_err       (w_out_err)
    );

    assign fft_reset    = r_rst_sr[1];
    assign fft_valid    = r_fft_valid;
    assign fft_data_i   = r_fft_i;
    assign fft_data_q   = r_fft_q;
    assign busy         = (r_state != IN_IDLE);
    assign sym_cnt      = r_sym_cnt;
    assign overrun_cnt  = r_ovr_cnt;
    assign sync_err_cnt = r_sync_cnt;
    assign out_err_cnt  = r_oerr_cnt;

endmodule

// File: tb/tb_fft_frame_ctrl.sv
// Randomized bench for fft_frame_ctrl; the bench itself plays myFFT and the downstream sink.
module tb_fft_frame_ctrl;

    localparam int SB = 8, DW = 16, OW = 22, CW = 3, NFFT = 256, CMAX = 7;

    logic          clk = 1'b0, reset_n = 1'b0, enable = 1'b0;
    logic [SB-1:0] cp_len = '0;
    logic          sym_start = 1'b0, in_valid = 1'b0;
    logic [DW-1:0] in_i = '0, in_q = '0;
    logic          fft_wayt_data = 1'b0, fft_complete = 1'b0, out_ready = 1'b0;
    logic [OW-1:0] fft_out_i = '0, fft_out_q = '0;

    logic          fft_reset, fft_valid, fft_ready_recive, out_valid, out_last, busy;
    logic [DW-1:0] fft_data_i, fft_data_q;
    logic [OW-1:0] out_i, out_q;
    logic [SB-1:0] out_bin;
    logic [CW-1:0] sym_cnt, overrun_cnt, sync_err_cnt, out_err_cnt;
    logic [100:0]  w_all;

    int n_pass = 0, n_chk = 0;
    int e_sym = 0, e_ovr = 0, e_sync = 0, e_oerr = 0;
    bit gaps = 1'b0;
    logic [63:0] fedq[$], outq[$], sentq[$], expq[$], expoq[$];

    always #5 clk = ~clk;

    fft_frame_ctrl #(
        .SIZE_BUFFER(SB), .DATA_FFT_SIZE(DW), .DATA_OUT_SIZE(OW), .CNT_W(CW)
    ) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable), .cp_len(cp_len),
        .sym_start(sym_start), .in_valid(in_valid), .in_i(in_i), .in_q(in_q),
        .fft_reset(fft_reset), .fft_valid(fft_valid),
        .fft_data_i(fft_data_i), .fft_data_q(fft_data_q),
        .fft_wayt_data(fft_wayt_data), .fft_ready_recive(fft_ready_recive),
        .fft_complete(fft_complete), .fft_out_i(fft_out_i), .fft_out_q(fft_out_q),
        .out_ready(out_ready), .out_valid(out_valid), .out_i(out_i), .out_q(out_q),
        .out_bin(out_bin), .out_last(out_last), .busy(busy),
        .sym_cnt(sym_cnt), .overrun_cnt(overrun_cnt),
        .sync_err_cnt(sync_err_cnt), .out_err_cnt(out_err_cnt)
    );

    assign w_all = {fft_valid, fft_data_i, fft_data_q, fft_ready_recive, out_valid, out_i, out_q,
                    out_bin, out_last, busy, sym_cnt, overrun_cnt, sync_err_cnt, out_err_cnt};

    always @(negedge clk) begin
        if (fft_valid) fedq.push_back({32'd0, fft_data_i, fft_data_q});
        if (out_valid) outq.push_back({11'd0, out_i, out_q, out_bin, out_last});
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    function automatic int sat(input int v);
        return (v > CMAX) ? CMAX : v;
    endfunction

    // -2 for a length difference, else index of first differing entry, -1 when identical
    function automatic int first_diff(input logic [63:0] a[$], input logic [63:0] b[$]);
        if (a.size() != b.size()) return -2;
        for (int k = 0; k < a.size(); k++) if (a[k] !== b[k]) return k;
        return -1;
    endfunction

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin tick(); in_valid = 1'b0; sym_start = 1'b0; end
    endtask

    task automatic send(input int n, input bit with_sym);
        for (int k = 0; k < n; k++) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                tick(); in_valid = 1'b0; sym_start = 1'b0;
            end
            tick();
            in_valid  = 1'b1;
            sym_start = with_sym && (k == 0);
            in_i      = DW'($urandom);
            in_q      = DW'($urandom);
            sentq.push_back({32'd0, in_i, in_q});
        end
    endtask

    task automatic wait_fed(input int n);
        for (int c = 0; c < 2000 && fedq.size() < n; c++) @(posedge clk);
        idle(3);
    endtask

    task automatic burst(input int drop_at, output int viol, output bit started);
        started = 1'b0; viol = 0; out_ready = 1'b1;
        for (int c = 0; c < 200; c++) begin
            if (fft_ready_recive) begin started = 1'b1; break; end
            tick();
        end
        if (started) begin
            for (int k = 0; k < NFFT; k++) begin
                if (k > 0 && !fft_ready_recive) viol++;
                fft_complete = 1'b1;
                fft_out_i    = OW'($urandom);
                fft_out_q    = OW'($urandom);
                if (k == drop_at) out_ready = 1'b0;
                expoq.push_back({11'd0, fft_out_i, fft_out_q, SB'(k), (k == NFFT - 1)});
                tick();
            end
        end
        fft_complete = 1'b0; out_ready = 1'b1;
    endtask

    task automatic clear_q();
        fedq.delete(); outq.delete(); sentq.delete(); expq.delete(); expoq.delete();
    endtask

    task automatic test_reset();
        reset_n = 1'b0; out_ready = 1'b1;
        repeat (3) @(negedge clk);
        n_chk++; if (w_all !== '0) $display("FAIL reset_outputs: got %h, expected 0", w_all); else n_pass++;
        n_chk++; if (fft_reset !== 1'b1) $display("FAIL reset_fft_reset: got %b, expected 1", fft_reset); else n_pass++;
        @(posedge clk); #1 reset_n = 1'b1;
        @(negedge clk);
        n_chk++; if (fft_reset !== 1'b1) $display("FAIL rel_fft_reset0: got %b, expected 1", fft_reset); else n_pass++;
        @(negedge clk);
        n_chk++; if (fft_reset !== 1'b1) $display("FAIL rel_fft_reset1: got %b, expected 1", fft_reset); else n_pass++;
        @(negedge clk);
        n_chk++; if (fft_reset !== 1'b0) $display("FAIL rel_fft_reset2: got %b, expected 0", fft_reset); else n_pass++;
        enable = 1'b1; fft_wayt_data = 1'b1;
    endtask

    task automatic test_cp_symbol();
        int d;
        gaps = 1'b1; cp_len = 8'd32; clear_q();
        send(NFFT + 32, 1'b1); idle(2); wait_fed(NFFT);
        for (int k = 0; k < NFFT; k++) expq.push_back(sentq[32 + k]);
        e_sym++;
        d = first_diff(fedq, expq);
        n_chk++; if (fedq.size() != NFFT) $display("FAIL cp_count: got %0d, expected %0d", fedq.size(), NFFT); else n_pass++;
        n_chk++; if (d != -1) $display("FAIL cp_data: first diff at %0d, expected none", d); else n_pass++;
        n_chk++; if (fedq.size() == 0 || fedq[0] !== sentq[32]) $display("FAIL cp_first: got %h, expected %h", (fedq.size() > 0) ? fedq[0] : 64'hx, sentq[32]); else n_pass++;
        n_chk++; if (int'(sym_cnt) != sat(e_sym)) $display("FAIL cp_sym_cnt: got %0d, expected %0d", sym_cnt, sat(e_sym)); else n_pass++;
        n_chk++; if (busy !== 1'b0) $display("FAIL cp_busy: got %b, expected 0", busy); else n_pass++;
    endtask

    task automatic test_back_to_back();
        int d;
        gaps = 1'b0; cp_len = '0; clear_q();
        send(NFFT, 1'b1); send(NFFT, 1'b1); idle(2); wait_fed(2 * NFFT);
        for (int k = 0; k < 2 * NFFT; k++) expq.push_back(sentq[k]);
        e_sym += 2;
        d = first_diff(fedq, expq);
        n_chk++; if (fedq.size() != 2 * NFFT) $display("FAIL b2b_count: got %0d, expected %0d", fedq.size(), 2 * NFFT); else n_pass++;
        n_chk++; if (d != -1) $display("FAIL b2b_data: first diff at %0d, expected none", d); else n_pass++;
        n_chk++; if (int'(sym_cnt) != sat(e_sym)) $display("FAIL b2b_sym_cnt: got %0d, expected %0d", sym_cnt, sat(e_sym)); else n_pass++;
        n_chk++; if (int'(overrun_cnt) != sat(e_ovr)) $display("FAIL b2b_overrun: got %0d, expected %0d", overrun_cnt, sat(e_ovr)); else n_pass++;
    endtask

    task automatic test_early_sync();
        int d;
        gaps = 1'b1; cp_len = 8'd4; clear_q();
        send(104, 1'b1);
        for (int k = 0; k < 100; k++) expq.push_back(sentq[4 + k]);
        for (int k = 100; k < NFFT; k++) expq.push_back(64'd0);
        send(20, 1'b1);
        send(5, 1'b1);
        idle(2); wait_fed(NFFT);
        e_sync++; e_ovr++;
        d = first_diff(fedq, expq);
        n_chk++; if (fedq.size() != NFFT) $display("FAIL sync_count: got %0d, expected %0d", fedq.size(), NFFT); else n_pass++;
        n_chk++; if (d != -1) $display("FAIL sync_data: first diff at %0d, expected none", d); else n_pass++;
        n_chk++; if (int'(sync_err_cnt) != sat(e_sync)) $display("FAIL sync_err_cnt: got %0d, expected %0d", sync_err_cnt, sat(e_sync)); else n_pass++;
        n_chk++; if (int'(overrun_cnt) != sat(e_ovr)) $display("FAIL sync_fill_overrun: got %0d, expected %0d", overrun_cnt, sat(e_ovr)); else n_pass++;
        n_chk++; if (int'(sym_cnt) != sat(e_sym)) $display("FAIL sync_sym_cnt: got %0d, expected %0d", sym_cnt, sat(e_sym)); else n_pass++;
    endtask

    task automatic test_drop();
        int d;
        gaps = 1'b1; cp_len = 8'd8; clear_q(); fft_wayt_data = 1'b1;
        send(NFFT + 8, 1'b1);
        for (int k = 0; k < NFFT; k++) expq.push_back(sentq[8 + k]);
        idle(1); fft_wayt_data = 1'b0;
        send(NFFT + 8, 1'b1); idle(2); wait_fed(NFFT);
        e_sym++; e_ovr++;
        d = first_diff(fedq, expq);
        n_chk++; if (d != -1) $display("FAIL drop_data: first diff at %0d (got %0d samples), expected none", d, fedq.size()); else n_pass++;
        n_chk++; if (int'(overrun_cnt) != sat(e_ovr)) $display("FAIL drop_overrun: got %0d, expected %0d", overrun_cnt, sat(e_ovr)); else n_pass++;
        n_chk++; if (busy !== 1'b1) $display("FAIL drop_busy: got %b, expected 1", busy); else n_pass++;
        gaps = 1'b0; fedq.delete();
        for (int k = 0; k < 10; k++) begin send(1, 1'b1); idle(1); end
        e_ovr += 10;
        n_chk++; if (int'(overrun_cnt) != sat(e_ovr)) $display("FAIL drop_saturate: got %0d, expected %0d", overrun_cnt, sat(e_ovr)); else n_pass++;
        n_chk++; if (fedq.size() != 0) $display("FAIL drop_no_feed: got %0d samples, expected 0", fedq.size()); else n_pass++;
    endtask

    task automatic test_enable();
        enable = 1'b0; fft_wayt_data = 1'b1; cp_len = '0; gaps = 1'b1; clear_q();
        send(NFFT, 1'b1); idle(3);
        n_chk++; if (fedq.size() != 0) $display("FAIL enable_no_feed: got %0d samples, expected 0", fedq.size()); else n_pass++;
        n_chk++; if (busy !== 1'b0) $display("FAIL enable_busy: got %b, expected 0", busy); else n_pass++;
        n_chk++; if (int'(sym_cnt) != sat(e_sym)) $display("FAIL enable_sym_cnt: got %0d, expected %0d", sym_cnt, sat(e_sym)); else n_pass++;
        enable = 1'b1;
    endtask

    task automatic test_drain();
        int viol, d; bit started;
        clear_q();
        burst(10, viol, started); idle(3);
        e_oerr++;
        d = first_diff(outq, expoq);
        n_chk++; if (!started) $display("FAIL drain_start: got no ready, expected fft_ready_recive"); else n_pass++;
        n_chk++; if (viol != 0) $display("FAIL drain_ready_hold: got %0d low cycles, expected 0", viol); else n_pass++;
        n_chk++; if (outq.size() != NFFT) $display("FAIL drain_count: got %0d, expected %0d", outq.size(), NFFT); else n_pass++;
        n_chk++; if (d != -1) $display("FAIL drain_data: first diff at %0d, expected none", d); else n_pass++;
        n_chk++; if (int'(out_err_cnt) != sat(e_oerr)) $display("FAIL drain_out_err: got %0d, expected %0d", out_err_cnt, sat(e_oerr)); else n_pass++;
    endtask

    task automatic test_concurrent();
        int viol, d, d2; bit started;
        gaps = 1'b1; cp_len = 8'd4; clear_q();
        fork
            send(NFFT + 4, 1'b1);
            burst(-1, viol, started);
        join
        idle(2); wait_fed(NFFT);
        for (int k = 0; k < NFFT; k++) expq.push_back(sentq[4 + k]);
        e_sym++;
        d  = first_diff(fedq, expq);
        d2 = first_diff(outq, expoq);
        n_chk++; if (d != -1) $display("FAIL conc_feed: first diff at %0d (got %0d samples), expected none", d, fedq.size()); else n_pass++;
        n_chk++; if (!started || d2 != -1) $display("FAIL conc_drain: first diff at %0d (got %0d samples), expected none", d2, outq.size()); else n_pass++;
        n_chk++; if (int'(out_err_cnt) != sat(e_oerr)) $display("FAIL conc_out_err: got %0d, expected %0d", out_err_cnt, sat(e_oerr)); else n_pass++;
        n_chk++; if (int'(sym_cnt) != sat(e_sym)) $display("FAIL conc_sym_cnt: got %0d, expected %0d", sym_cnt, sat(e_sym)); else n_pass++;
    endtask

    task automatic test_reset_mid();
        int d;
        gaps = 1'b0; cp_len = '0; clear_q(); out_ready = 1'b1;
        send(50, 1'b1); idle(1);
        tick(); reset_n = 1'b0; in_valid = 1'b0; sym_start = 1'b0;
        e_sym = 0; e_ovr = 0; e_sync = 0; e_oerr = 0;
        @(negedge clk);
        n_chk++; if (fedq.size() != 50) $display("FAIL mid_pre_count: got %0d, expected 50", fedq.size()); else n_pass++;
        n_chk++; if (w_all !== '0) $display("FAIL mid_outputs: got %h, expected 0", w_all); else n_pass++;
        n_chk++; if (fft_reset !== 1'b1) $display("FAIL mid_fft_reset: got %b, expected 1", fft_reset); else n_pass++;
        @(posedge clk); #1 reset_n = 1'b1;
        @(negedge clk);
        n_chk++; if (fft_reset !== 1'b1) $display("FAIL mid_rel0: got %b, expected 1", fft_reset); else n_pass++;
        @(negedge clk);
        n_chk++; if (fft_reset !== 1'b1) $display("FAIL mid_rel1: got %b, expected 1", fft_reset); else n_pass++;
        @(negedge clk);
        n_chk++; if (fft_reset !== 1'b0) $display("FAIL mid_rel2: got %b, expected 0", fft_reset); else n_pass++;
        gaps = 1'b1; cp_len = 8'd16; clear_q();
        send(NFFT + 16, 1'b1); idle(2); wait_fed(NFFT);
        for (int k = 0; k < NFFT; k++) expq.push_back(sentq[16 + k]);
        e_sym++;
        d = first_diff(fedq, expq);
        n_chk++; if (d != -1) $display("FAIL mid_next_data: first diff at %0d (got %0d samples), expected none", d, fedq.size()); else n_pass++;
        n_chk++; if (int'(sym_cnt) != sat(e_sym)) $display("FAIL mid_sym_cnt: got %0d, expected %0d", sym_cnt, sat(e_sym)); else n_pass++;
        n_chk++; if (int'(overrun_cnt) != sat(e_ovr)) $display("FAIL mid_overrun: got %0d, expected %0d", overrun_cnt, sat(e_ovr)); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_cp_symbol();
        test_back_to_back();
        test_early_sync();
        test_drop();
        test_enable();
        test_drain();
        test_concurrent();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
